operand_skew_loader: RTL and testbench
======================================

# operand_skew_loader

Synthesisable successor to the file-driven operand stimulus used around `Top`. It takes the UART word stream (`RDATA`/`RVALID`), loads an A bank of `DEPTH` vectors × `UNITS_X` lanes and a B bank of `DEPTH` vectors × `UNITS_Y` lanes, then replays both banks into the systolic array. Replay is diagonally skewed, with lane i delayed i cycles, under a valid/ready handshake. It sits between the UART receiver and the systolic array inside `Top`.

## Interface
- `BITWIDTH`, 16, word width
- `UNITS_X`, 3, A lanes (array columns)
- `UNITS_Y`, 3, B lanes (array rows)
- `DEPTH`, 3, vectors per bank (inner dimension K), ≥1
- `AUTO_START`, 0, 1 = begin replay immediately after loading; 0 = wait for `START`
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  asynchronous, active-high reset
- `RDATA`  in  BITWIDTH  incoming word
- `RVALID`  in  1  `RDATA` valid this cycle
- `RREADY`  out  1  loader accepts a word this cycle
- `START`  in  1  replay request (level, sampled in ARMED)
- `OREADY`  in  1  array accepts the current output beat
- `OVALID`  out  1  `OP1`/`OP2` beat valid
- `OP1`  out  BITWIDTH*UNITS_X  A lanes, lane i at `[i*BITWIDTH +: BITWIDTH]`
- `OP2`  out  BITWIDTH*UNITS_Y  B lanes, same packing
- `DONE`  out  1  one-cycle pulse after the final beat
- `OVERRUN`  out  1  sticky: `RVALID` seen while `RREADY`=0

## Operation
- States: LOAD_A → LOAD_B → ARMED → PLAY → LOAD_A.
- Reset values: state LOAD_A, counters 0, banks 0, `OVALID`=0, `OP1`=`OP2`=0, `DONE`=0, `OVERRUN`=0. `RREADY` is 1 after reset.
- LOAD_A:
  - `RREADY`=1.
  - An accepted word (`RVALID`&`RREADY`) is written to A[k][i], in vector-major order: i increments first, then k.
  - After DEPTH*UNITS_X accepted words, go to LOAD_B.
- LOAD_B: the same for B[k][j] with DEPTH*UNITS_Y words. Then go to ARMED, or directly to PLAY if `AUTO_START`=1.
- ARMED: `RREADY`=0. `START`=1 moves to PLAY on the next edge.
- PLAY:
  - Beat counter t runs 0..PLAY_LEN-1, where PLAY_LEN = DEPTH + max(UNITS_X,UNITS_Y) − 1.
  - Lane i of `OP1` = A[t−i][i] when 0 ≤ t−i < DEPTH, else 0. `OP2` follows the same rule with B.
  - t advances only when `OVALID`&`OREADY`.
  - When the last beat is accepted, go to LOAD_A and pulse `DONE`.
- Bank contents persist after PLAY and are overwritten by the next load.
- `OVERRUN` sets on `RVALID`=1 with `RREADY`=0 (ARMED or PLAY). The word is dropped. The flag clears only on `RST`.
- `START` is ignored outside ARMED. `OREADY` is ignored outside PLAY.

## Timing
- Word acceptance takes zero wait states: one word per cycle when `RVALID` is held high.
- The last B word is accepted at edge n. At n+1 the state is ARMED, or PLAY when `AUTO_START`=1.
- `START` is seen high in ARMED at edge m. At m+1, `OVALID`=1 and the t=0 beat is presented.
- `OVALID`, `OP1` and `OP2` are registered, with no combinational path from `OREADY`/`RDATA`. Outputs are held stable while `OVALID`&!`OREADY`.
- Replay with `OREADY` tied high lasts exactly PLAY_LEN cycles.
- `DONE` is high in the cycle after the final accepted beat. In that same cycle `OVALID`=0 and `RREADY`=1.
- `RST` asserted mid-load or mid-play clears everything immediately. A partial load is discarded.

## Structure
- Shared package `systolic_pkg`: state enum (LOAD_A, LOAD_B, ARMED, PLAY) and a `play_len(depth, ux, uy)` function. `BITWIDTH`/`UNITS_*` defaults live there too, shared with `Top`.
- Sub-module `skew_bank`, instantiated twice (A with UNITS_X, B with UNITS_Y):
  - holds the DEPTH×UNITS storage, write port (k, i, data, we);
  - given t, produces the skewed lane vector with zero padding.
- Top level of the block holds the FSM, counters, handshake and `OVERRUN`.

## Test plan
All scenarios use defaults with A words 1..9 (A[k][i]=1+3k+i) and B words 10..18.
1. Load all 18 words back to back, then `START` pulse, `OREADY`=1. Required beats, in order:
   - `OP1` lanes (0→2): {1,0,0}, {4,2,0}, {7,5,3}, {0,8,6}, {0,0,9}.
   - `OP2` follows the same pattern with base 10.
   - Exactly 5 `OVALID` cycles, then a `DONE` pulse.
2. `OREADY` low for 3 cycles at t=2 → beat {7,5,3} is held for 4 cycles, the total becomes 8 `OVALID` cycles, and data is unchanged.
3. `RVALID` pulsed in ARMED with `RDATA`=99 → `OVERRUN`=1 and stays 1. Replay is identical to scenario 1.
4. `AUTO_START`=1 → `OVALID` rises the cycle after the 18th word with no `START`.
5. `RST` asserted after 7 words, then all 18 words reloaded → outputs are zero during reset, and replay matches scenario 1.
6. `UNITS_X`=2, `UNITS_Y`=4, `DEPTH`=1 → PLAY_LEN=4:
   - `OP1`: {a0,0}, {0,a1}, {0,0}, {0,0};
   - `OP2`: a diagonal over 4 beats.

Source files
------------

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Definitions shared by the systolic array top level and the operand skew
//   loader: default datapath geometry, the loader state encoding and small
//   constant helpers used to size counters and replay length.
// -----------------------------------------------------------------------------
package systolic_pkg;

    // Default geometry, also used by Top so the array and loader agree.
    localparam int BITWIDTH_DEF = 16;
    localparam int UNITS_X_DEF  = 3;
    localparam int UNITS_Y_DEF  = 3;
    localparam int DEPTH_DEF    = 3;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ARMED  = 2'd2,
        PLAY   = 2'd3
    } state_t;

    // Number of beats in one skewed replay: the last lane starts
    // max(ux,uy)-1 beats late and then needs depth beats of data.
    function automatic int play_len(input int depth, input int ux, input int uy);
        int umax;
        umax = (ux > uy) ? ux : uy;
        return depth + umax - 1;
    endfunction

    // Index width for an n-entry dimension; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skew_bank.sv
// -----------------------------------------------------------------------------
// skew_bank
//   DEPTH x UNITS operand storage with one write port and a diagonally skewed
//   read: for beat t, lane u returns mem[t-u][u] when 0 <= t-u < DEPTH and
//   zero otherwise. The read is combinational; the caller registers it.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset, clears the whole bank
//   we_i     : write strobe
//   wk_i     : write vector index k
//   wi_i     : write lane index
//   wdata_i  : write data
//   t_i      : beat index for the skewed read
//   lanes_o  : skewed lane vector, lane u at [u*BITWIDTH +: BITWIDTH]
// -----------------------------------------------------------------------------
module skew_bank
    import systolic_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF,
    parameter int UNITS    = UNITS_X_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TW       = 3,
    parameter int KW       = idx_w(DEPTH),
    parameter int UIW      = idx_w(UNITS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [KW-1:0]             wk_i,
    input  logic [UIW-1:0]            wi_i,
    input  logic [BITWIDTH-1:0]       wdata_i,
    input  logic [TW-1:0]             t_i,
    output logic [BITWIDTH*UNITS-1:0] lanes_o
);

    localparam int TW1 = TW + 1;

    // Every lane is read in the same cycle, so the storage is a register
    // array rather than a RAM; it also has to come out of reset as zeros.
    logic [BITWIDTH-1:0] mem_q [DEPTH][UNITS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                for (int u = 0; u < UNITS; u++) begin
                    mem_q[k][u] <= '0;
                end
            end
        end else if (we_i) begin
            mem_q[wk_i][wi_i] <= wdata_i;
        end
    end

    for (genvar gi = 0; gi < UNITS; gi++) begin : g_lane
        logic [TW:0]         diff_w;
        logic [KW-1:0]       k_w;
        logic                hit_w;
        logic [BITWIDTH-1:0] val_w;

        // One extra bit catches t < lane (the borrow) without a signed compare.
        assign diff_w = {1'b0, t_i} - TW1'(gi);
        assign k_w    = KW'(diff_w[TW-1:0]);
        assign hit_w  = !diff_w[TW] && (diff_w[TW-1:0] < TW'(DEPTH));

        always_comb begin
            val_w = '0;
            if (hit_w) begin
                // Forward the word being written this cycle so a replay that
                // starts on the same edge as the final write sees it.
                if (we_i && (wk_i == k_w) && (wi_i == UIW'(gi))) begin
                    val_w = wdata_i;
                end else begin
                    val_w = mem_q[k_w][gi];
                end
            end
        end

        assign lanes_o[gi*BITWIDTH +: BITWIDTH] = val_w;
    end

endmodule

// File: rtl/operand_skew_loader.sv
// -----------------------------------------------------------------------------
// operand_skew_loader
//   Loads an A bank (DEPTH x UNITS_X) and a B bank (DEPTH x UNITS_Y) from the
//   UART word stream in vector-major order, then replays both banks into the
//   systolic array with lane i delayed i beats, under OVALID/OREADY.
//
// Ports
//   CLK      : clock, rising edge
//   RST      : asynchronous active-high reset
//   RDATA    : incoming word
//   RVALID   : RDATA valid this cycle
//   RREADY   : loader accepts a word this cycle (LOAD_A / LOAD_B)
//   START    : replay request, only looked at in ARMED
//   OREADY   : array accepts the current beat, only looked at in PLAY
//   OVALID   : OP1/OP2 beat valid
//   OP1      : A lanes, lane i at [i*BITWIDTH +: BITWIDTH]
//   OP2      : B lanes, same packing
//   DONE     : one-cycle pulse after the final accepted beat
//   OVERRUN  : sticky, a word arrived while RREADY was low (word dropped)
// -----------------------------------------------------------------------------
module operand_skew_loader
    import systolic_pkg::*;
#(
    parameter int BITWIDTH   = BITWIDTH_DEF,
    parameter int UNITS_X    = UNITS_X_DEF,
    parameter int UNITS_Y    = UNITS_Y_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter bit AUTO_START = 1'b0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [BITWIDTH-1:0]         RDATA,
    input  logic                        RVALID,
    output logic                        RREADY,
    input  logic                        START,
    input  logic                        OREADY,
    output logic                        OVALID,
    output logic [BITWIDTH*UNITS_X-1:0] OP1,
    output logic [BITWIDTH*UNITS_Y-1:0] OP2,
    output logic                        DONE,
    output logic                        OVERRUN
);

    localparam int PLAY_LEN = play_len(DEPTH, UNITS_X, UNITS_Y);
    localparam int UMAX     = (UNITS_X > UNITS_Y) ? UNITS_X : UNITS_Y;
    localparam int IW       = idx_w(UMAX);
    localparam int KW       = idx_w(DEPTH);
    localparam int TW       = $clog2(PLAY_LEN + 1);
    localparam int AIW      = idx_w(UNITS_X);
    localparam int BIW      = idx_w(UNITS_Y);

    localparam logic [IW-1:0] LAST_X = IW'(UNITS_X - 1);
    localparam logic [IW-1:0] LAST_Y = IW'(UNITS_Y - 1);
    localparam logic [KW-1:0] LAST_K = KW'(DEPTH - 1);
    localparam logic [TW-1:0] LAST_T = TW'(PLAY_LEN - 1);

    state_t                        state_q;
    logic [IW-1:0]                 lane_q;
    logic [KW-1:0]                 vec_q;
    logic [TW-1:0]                 t_q;
    logic                          ovalid_q;
    logic [BITWIDTH*UNITS_X-1:0]   op1_q;
    logic [BITWIDTH*UNITS_Y-1:0]   op2_q;
    logic                          done_q;
    logic                          overrun_q;
    logic                          rready_q;

    logic                          we_a;
    logic                          we_b;
    logic [TW-1:0]                 rd_t;
    logic [BITWIDTH*UNITS_X-1:0]   a_lanes;
    logic [BITWIDTH*UNITS_Y-1:0]   b_lanes;

    assign we_a = (state_q == LOAD_A) && RVALID;
    assign we_b = (state_q == LOAD_B) && RVALID;

    // The banks are read one beat ahead: outside PLAY they present beat 0
    // (loaded on the transition into PLAY), inside PLAY the beat after t_q.
    assign rd_t = (state_q == PLAY) ? (t_q + TW'(1)) : '0;

    skew_bank #(
        .BITWIDTH (BITWIDTH),
        .UNITS    (UNITS_X),
        .DEPTH    (DEPTH),
        .TW       (TW),
        .KW       (KW),
        .UIW      (AIW)
    ) u_bank_a (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_i     (we_a),
        .wk_i     (vec_q),
        .wi_i     (AIW'(lane_q)),
        .wdata_i  (RDATA),
        .t_i      (rd_t),
        .lanes_o  (a_lanes)
    );

    skew_bank #(
        .BITWIDTH (BITWIDTH),
        .UNITS    (UNITS_Y),
        .DEPTH    (DEPTH),
        .TW       (TW),
        .KW       (KW),
        .UIW      (BIW)
    ) u_bank_b (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_i     (we_b),
        .wk_i     (vec_q),
        .wi_i     (BIW'(lane_q)),
        .wdata_i  (RDATA),
        .t_i      (rd_t),
        .lanes_o  (b_lanes)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= LOAD_A;
            lane_q    <= '0;
            vec_q     <= '0;
            t_q       <= '0;
            ovalid_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            rready_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;

            if (RVALID && !rready_q) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                LOAD_A: begin
                    if (RVALID) begin
                        if (lane_q == LAST_X) begin
                            lane_q <= '0;
                            if (vec_q == LAST_K) begin
                                vec_q   <= '0;
                                state_q <= LOAD_B;
                            end else begin
                                vec_q <= vec_q + KW'(1);
                            end
                        end else begin
                            lane_q <= lane_q + IW'(1);
                        end
                    end
                end

                LOAD_B: begin
                    if (RVALID) begin
                        if (lane_q == LAST_Y) begin
                            lane_q <= '0;
                            if (vec_q == LAST_K) begin
                                vec_q    <= '0;
                                rready_q <= 1'b0;
                                if (AUTO_START) begin
                                    state_q  <= PLAY;
                                    t_q      <= '0;
                                    ovalid_q <= 1'b1;
                                    op1_q    <= a_lanes;
                                    op2_q    <= b_lanes;
                                end else begin
                                    state_q <= ARMED;
                                end
                            end else begin
                                vec_q <= vec_q + KW'(1);
                            end
                        end else begin
                            lane_q <= lane_q + IW'(1);
                        end
                    end
                end

                ARMED: begin
                    if (START) begin
                        state_q  <= PLAY;
                        t_q      <= '0;
                        ovalid_q <= 1'b1;
                        op1_q    <= a_lanes;
                        op2_q    <= b_lanes;
                    end
                end

                PLAY: begin
                    if (ovalid_q && OREADY) begin
                        if (t_q == LAST_T) begin
                            state_q  <= LOAD_A;
                            t_q      <= '0;
                            ovalid_q <= 1'b0;
                            op1_q    <= '0;
                            op2_q    <= '0;
                            done_q   <= 1'b1;
                            rready_q <= 1'b1;
                        end else begin
                            t_q   <= t_q + TW'(1);
                            op1_q <= a_lanes;
                            op2_q <= b_lanes;
                        end
                    end
                end

                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

    assign RREADY  = rready_q;
    assign OVALID  = ovalid_q;
    assign OP1     = op1_q;
    assign OP2     = op2_q;
    assign DONE    = done_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_operand_skew_loader.sv
module tb_operand_skew_loader;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared stimulus (default and auto-start instances)
    logic        rst;
    logic [15:0] rdata;
    logic        rvalid;
    logic        start;
    logic        oready;

    // Default instance
    logic        m_rready, m_ovalid, m_done, m_overrun;
    logic [47:0] m_op1, m_op2;

    // AUTO_START=1 instance
    logic        a_rready, a_ovalid, a_done, a_overrun;
    logic [47:0] a_op1, a_op2;

    // UNITS_X=2, UNITS_Y=4, DEPTH=1 instance
    logic        s_rvalid, s_start;
    logic [15:0] s_rdata;
    logic        s_rready, s_ovalid, s_done, s_overrun;
    logic [31:0] s_op1;
    logic [63:0] s_op2;

    operand_skew_loader u_dut (
        .CLK(CLK), .RST(rst), .RDATA(rdata), .RVALID(rvalid), .RREADY(m_rready),
        .START(start), .OREADY(oready), .OVALID(m_ovalid), .OP1(m_op1), .OP2(m_op2),
        .DONE(m_done), .OVERRUN(m_overrun)
    );

    operand_skew_loader #(.AUTO_START(1'b1)) u_dut_auto (
        .CLK(CLK), .RST(rst), .RDATA(rdata), .RVALID(rvalid), .RREADY(a_rready),
        .START(1'b0), .OREADY(1'b1), .OVALID(a_ovalid), .OP1(a_op1), .OP2(a_op2),
        .DONE(a_done), .OVERRUN(a_overrun)
    );

    operand_skew_loader #(.UNITS_X(2), .UNITS_Y(4), .DEPTH(1)) u_dut_small (
        .CLK(CLK), .RST(rst), .RDATA(s_rdata), .RVALID(s_rvalid), .RREADY(s_rready),
        .START(s_start), .OREADY(1'b1), .OVALID(s_ovalid), .OP1(s_op1), .OP2(s_op2),
        .DONE(s_done), .OVERRUN(s_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Required OP1 lanes (0..2) per beat for A[k][i] = 1+3k+i; OP2 is the same
    // pattern with every non-zero entry offset by 9 (B words 10..18).
    int tbl [5][3] = '{'{1,0,0}, '{4,2,0}, '{7,5,3}, '{0,8,6}, '{0,0,9}};

    logic [95:0] exp_q [$];
    logic [95:0] exp_beat;
    logic [95:0] held = '0;
    logic        hold_pend = 1'b0;
    int          ov_cnt = 0;

    // Output monitor: pops one expected beat per accepted beat, and checks
    // that a stalled beat stays unchanged.
    always @(negedge CLK) begin
        if (hold_pend) chk("hold", {m_op1, m_op2}, held);
        hold_pend = m_ovalid && !oready;
        held      = {m_op1, m_op2};
        if (m_ovalid) begin
            ov_cnt++;
            if (oready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("beat", {m_op1, m_op2}, exp_beat);
                end
            end
        end
    end

    task automatic send_word(input logic [15:0] w);
        rvalid = 1'b1;
        rdata  = w;
        @(posedge CLK); #1;
        rvalid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 9; i++) send_word(16'(i + 1));
        for (int i = 0; i < 9; i++) send_word(16'(i + 10));
    endtask

    task automatic push_beats();
        logic [95:0] e;
        for (int t = 0; t < 5; t++) begin
            e = '0;
            for (int i = 0; i < 3; i++) begin
                e[48 + i*16 +: 16] = 16'(tbl[t][i]);
                if (tbl[t][i] != 0) e[i*16 +: 16] = 16'(tbl[t][i] + 9);
            end
            exp_q.push_back(e);
        end
    endtask

    // Start a replay and run it with OREADY low for cycles [s, s+l).
    task automatic play(input int s, input int l, input int exp_cycles, input string tag);
        logic got_done;
        push_beats();
        ov_cnt = 0;
        start  = 1'b1;
        @(posedge CLK); #1;
        start  = 1'b0;
        chk({tag, "_ovalid_rise"}, m_ovalid, 1);
        got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            oready = (c >= s && c < s + l) ? 1'b0 : 1'b1;
            @(posedge CLK); #1;
            if (m_done) got_done = 1'b1;
        end
        oready = 1'b1;
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_ovalid_cycles"}, ov_cnt, exp_cycles);
        chk({tag, "_ovalid_low_at_done"}, m_ovalid, 0);
        chk({tag, "_rready_at_done"}, m_rready, 1);
        chk({tag, "_sb_drained"}, exp_q.size(), 0);
        @(posedge CLK); #1;
        chk({tag, "_done_pulse"}, m_done, 0);
    endtask

    int sw [6] = '{21, 22, 31, 32, 33, 34};

    initial begin
        logic [31:0] e1;
        logic [63:0] e2;

        rst = 1'b1; rvalid = 1'b0; rdata = '0; start = 1'b0; oready = 1'b1;
        s_rvalid = 1'b0; s_rdata = '0; s_start = 1'b0;
        repeat (3) @(posedge CLK); #1;
        chk("rst_ovalid",  m_ovalid, 0);
        chk("rst_ops",     {m_op1, m_op2}, 0);
        chk("rst_done",    m_done, 0);
        chk("rst_overrun", m_overrun, 0);
        chk("rst_rready",  m_rready, 1);
        rst = 1'b0;

        // 1: back-to-back load, START pulse, OREADY high
        load_all();
        chk("s1_armed_rready", m_rready, 0);
        chk("s1_armed_ovalid", m_ovalid, 0);
        // 4: auto-start instance loaded the same stream
        chk("s4_auto_ovalid", a_ovalid, 1);
        chk("s4_auto_beat0", {a_op1, a_op2}, {32'd0, 16'd1, 32'd0, 16'd10});
        play(0, 0, 5, "s1");

        // 2: OREADY low for 3 cycles at t=2
        load_all();
        play(2, 3, 8, "s2");

        // 3: word arriving in ARMED is dropped and flags OVERRUN
        load_all();
        send_word(16'd99);
        chk("s3_overrun", m_overrun, 1);
        play(0, 0, 5, "s3");
        chk("s3_overrun_sticky", m_overrun, 1);

        // 5: reset after 7 words, then full reload
        for (int i = 0; i < 7; i++) send_word(16'(i + 1));
        rst = 1'b1;
        #1;
        chk("s5_async_overrun_clr", m_overrun, 0);
        chk("s5_rst_rready", m_rready, 1);
        chk("s5_rst_ops", {m_op1, m_op2}, 0);
        repeat (2) @(posedge CLK); #1;
        rst = 1'b0;
        load_all();
        play(0, 0, 5, "s5");

        // Reset in the middle of a replay
        load_all();
        push_beats();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        rst = 1'b1;
        #1;
        chk("mp_ovalid", m_ovalid, 0);
        chk("mp_ops", {m_op1, m_op2}, 0);
        exp_q.delete();
        repeat (2) @(posedge CLK); #1;
        rst = 1'b0;

        // 6: UNITS_X=2, UNITS_Y=4, DEPTH=1
        for (int i = 0; i < 6; i++) begin
            s_rvalid = 1'b1;
            s_rdata  = 16'(sw[i]);
            @(posedge CLK); #1;
            s_rvalid = 1'b0;
        end
        chk("s6_armed_rready", s_rready, 0);
        s_start = 1'b1;
        @(posedge CLK); #1;
        s_start = 1'b0;
        for (int t = 0; t < 4; t++) begin
            e1 = '0;
            e2 = '0;
            if (t < 2) e1[t*16 +: 16] = 16'(sw[t]);
            e2[t*16 +: 16] = 16'(sw[2 + t]);
            chk("s6_ovalid", s_ovalid, 1);
            chk("s6_op1", s_op1, e1);
            chk("s6_op2", s_op2, e2);
            @(posedge CLK); #1;
        end
        chk("s6_done", s_done, 1);
        chk("s6_ovalid_low", s_ovalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
